// File: rtl/rvfi_check_pkg.sv
// Shared error-bit definitions for the RVFI retirement trace checker.
package rvfi_check_pkg;

    localparam int ERR_W = 8;

    typedef logic [ERR_W-1:0] err_vec_t;

    // Bit positions inside err_code / err_first_code.
    localparam int ERR_ORDER   = 0;
    localparam int ERR_PC      = 1;
    localparam int ERR_RS1     = 2;
    localparam int ERR_RS2     = 3;
    localparam int ERR_X0WR    = 4;
    localparam int ERR_POSTHLT = 5;
    localparam int ERR_TRAPWB  = 6;
    localparam int ERR_ALIGN   = 7;

endpackage

// File: rtl/rvfi_shadow_regfile.sv
// Shadow copy of the architectural register file, built only from retired writes.
// A register reads back as valid only once it has been written; x0 is never valid.
module rvfi_shadow_regfile #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            i_we,
    input  logic [4:0]      i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [4:0]      i_ra1,
    output logic [XLEN-1:0] o_rd1,
    output logic            o_rv1,
    input  logic [4:0]      i_ra2,
    output logic [XLEN-1:0] o_rd2,
    output logic            o_rv2
);

    logic [XLEN-1:0] r_data [32];
    logic [31:0]     r_vld;

    // Register values: no reset needed, the valid bits gate every use.
    always_ff @(posedge clock) begin
        if (i_we && (i_waddr != 5'd0)) begin
            r_data[i_waddr] <= i_wdata;
        end
    end

    // Valid bits: cleared by reset, set by the first write to each register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_vld <= '0;
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_vld[i_waddr] <= 1'b1;
        end
    end

    assign o_rv1 = (i_ra1 != 5'd0) && r_vld[i_ra1];
    assign o_rd1 = (i_ra1 != 5'd0) ? r_data[i_ra1] : '0;
    assign o_rv2 = (i_ra2 != 5'd0) && r_vld[i_ra2];
    assign o_rd2 = (i_ra2 != 5'd0) ? r_data[i_ra2] : '0;

endmodule

// File: rtl/rvfi_trace_checker.sv
// RVFI retirement-port consistency checker: order, PC continuity, register
// read-after-write against a shadow regfile, x0, halt, trap and alignment rules.
// Errors are sticky; the first failing beat's code/order/insn are latched.
module rvfi_trace_checker
    import rvfi_check_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ORDER_W   = 64,
    parameter int CHECK_ALN = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               err_clear,
    input  logic               rvfi_valid,
    input  logic [ORDER_W-1:0] rvfi_order,
    input  logic [31:0]        rvfi_insn,
    input  logic               rvfi_trap,
    input  logic               rvfi_halt,
    input  logic [4:0]         rvfi_rs1_addr,
    input  logic [4:0]         rvfi_rs2_addr,
    input  logic [XLEN-1:0]    rvfi_rs1_rdata,
    input  logic [XLEN-1:0]    rvfi_rs2_rdata,
    input  logic [4:0]         rvfi_rd_addr,
    input  logic [XLEN-1:0]    rvfi_rd_wdata,
    input  logic [XLEN-1:0]    rvfi_pc_rdata,
    input  logic [XLEN-1:0]    rvfi_pc_wdata,
    output logic               err,
    output logic [ERR_W-1:0]   err_code,
    output logic [ERR_W-1:0]   err_first_code,
    output logic [ORDER_W-1:0] err_first_order,
    output logic [31:0]        err_first_insn,
    output logic [ORDER_W-1:0] retired,
    output logic               halted
);

    logic [ORDER_W-1:0] r_exp_order;
    logic [XLEN-1:0]    r_prev_pc;
    logic               r_have_prev;
    logic [ORDER_W-1:0] r_retired;
    logic               r_halted;
    logic               r_err;
    err_vec_t           r_err_code;
    err_vec_t           r_first_code;
    logic [ORDER_W-1:0] r_first_order;
    logic [31:0]        r_first_insn;

    logic               w_sh_we;
    logic [XLEN-1:0]    w_rs1_val;
    logic [XLEN-1:0]    w_rs2_val;
    logic               w_rs1_vld;
    logic               w_rs2_vld;
    err_vec_t           w_bits;

    // Trapped instructions never commit their rd write.
    assign w_sh_we = rvfi_valid && !rvfi_trap && (rvfi_rd_addr != 5'd0);

    rvfi_shadow_regfile #(.XLEN(XLEN)) u_shadow (
        .clock   (clock),
        .reset   (reset),
        .i_we    (w_sh_we),
        .i_waddr (rvfi_rd_addr),
        .i_wdata (rvfi_rd_wdata),
        .i_ra1   (rvfi_rs1_addr),
        .o_rd1   (w_rs1_val),
        .o_rv1   (w_rs1_vld),
        .i_ra2   (rvfi_rs2_addr),
        .o_rd2   (w_rs2_val),
        .o_rv2   (w_rs2_vld)
    );

    // Per-beat checks against the state left by the previous beat.
    always_comb begin
        w_bits = '0;
        if (rvfi_valid) begin
            w_bits[ERR_ORDER]   = (rvfi_order != r_exp_order);
            w_bits[ERR_PC]      = r_have_prev && (rvfi_pc_rdata != r_prev_pc);
            w_bits[ERR_RS1]     = ((rvfi_rs1_addr == 5'd0) && (rvfi_rs1_rdata != '0)) ||
                                  (w_rs1_vld && (rvfi_rs1_rdata != w_rs1_val));
            w_bits[ERR_RS2]     = ((rvfi_rs2_addr == 5'd0) && (rvfi_rs2_rdata != '0)) ||
                                  (w_rs2_vld && (rvfi_rs2_rdata != w_rs2_val));
            w_bits[ERR_X0WR]    = (rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != '0);
            w_bits[ERR_POSTHLT] = r_halted;
            w_bits[ERR_TRAPWB]  = rvfi_trap && (rvfi_rd_addr != 5'd0);
            w_bits[ERR_ALIGN]   = (CHECK_ALN != 0) && !rvfi_trap && (rvfi_pc_wdata[1:0] != 2'b00);
        end
    end

    // Order/PC trackers, retired counter and halt flag; they resync on every beat.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_exp_order <= '0;
            r_prev_pc   <= '0;
            r_have_prev <= 1'b0;
            r_retired   <= '0;
            r_halted    <= 1'b0;
        end else if (rvfi_valid) begin
            r_exp_order <= rvfi_order + ORDER_W'(1);
            r_prev_pc   <= rvfi_pc_wdata;
            r_have_prev <= 1'b1;
            if (r_retired != '1) begin
                r_retired <= r_retired + ORDER_W'(1);
            end
            if (rvfi_halt) begin
                r_halted <= 1'b1;
            end
        end
    end

    // Sticky error state and first-error latch; a clear still captures the same-cycle beat.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_err         <= 1'b0;
            r_err_code    <= '0;
            r_first_code  <= '0;
            r_first_order <= '0;
            r_first_insn  <= '0;
        end else if (err_clear) begin
            r_err         <= (w_bits != '0);
            r_err_code    <= w_bits;
            r_first_code  <= w_bits;
            r_first_order <= (w_bits != '0) ? rvfi_order : '0;
            r_first_insn  <= (w_bits != '0) ? rvfi_insn : '0;
        end else if (w_bits != '0) begin
            r_err      <= 1'b1;
            r_err_code <= r_err_code | w_bits;
            if (!r_err) begin
                r_first_code  <= w_bits;
                r_first_order <= rvfi_order;
                r_first_insn  <= rvfi_insn;
            end
        end
    end

    assign err             = r_err;
    assign err_code        = r_err_code;
    assign err_first_code  = r_first_code;
    assign err_first_order = r_first_order;
    assign err_first_insn  = r_first_insn;
    assign retired         = r_retired;
    assign halted          = r_halted;

endmodule

// File: tb/tb_rvfi_trace_checker.sv
// Testbench for rvfi_trace_checker: directed scenarios with literal expectations
// plus a randomized trace compared every cycle against a behavioural model.
module tb_rvfi_trace_checker;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        err_clear = 1'b0;
    logic        rvfi_valid = 1'b0;
    logic [63:0] rvfi_order = '0;
    logic [31:0] rvfi_insn = '0;
    logic        rvfi_trap = 1'b0;
    logic        rvfi_halt = 1'b0;
    logic [4:0]  rvfi_rs1_addr = '0;
    logic [4:0]  rvfi_rs2_addr = '0;
    logic [31:0] rvfi_rs1_rdata = '0;
    logic [31:0] rvfi_rs2_rdata = '0;
    logic [4:0]  rvfi_rd_addr = '0;
    logic [31:0] rvfi_rd_wdata = '0;
    logic [31:0] rvfi_pc_rdata = '0;
    logic [31:0] rvfi_pc_wdata = '0;
    logic        err;
    logic [7:0]  err_code;
    logic [7:0]  err_first_code;
    logic [63:0] err_first_order;
    logic [31:0] err_first_insn;
    logic [63:0] retired;
    logic        halted;

    rvfi_trace_checker dut (
        .clock(clock), .reset(reset), .err_clear(err_clear), .rvfi_valid(rvfi_valid),
        .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap),
        .rvfi_halt(rvfi_halt), .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .err(err), .err_code(err_code), .err_first_code(err_first_code),
        .err_first_order(err_first_order), .err_first_insn(err_first_insn),
        .retired(retired), .halted(halted)
    );

    always #5 clock = ~clock;

    // Behavioural model state
    logic [31:0] m_sh [32];
    bit          m_shv [32];
    logic [63:0] m_exp, m_retired, m_forder;
    logic [31:0] m_prev, m_finsn;
    bit          m_have, m_err, m_halted;
    logic [7:0]  m_code, m_fcode;

    int n_assert = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_sh[i]  = '0;
            m_shv[i] = 1'b0;
        end
        m_exp = '0; m_retired = '0; m_forder = '0; m_prev = '0; m_finsn = '0;
        m_have = 1'b0; m_err = 1'b0; m_halted = 1'b0; m_code = '0; m_fcode = '0;
    endfunction

    function automatic bit rs_bad(logic [4:0] a, logic [31:0] d);
        if (a == 5'd0) return d != 32'd0;
        return m_shv[a] && (d != m_sh[a]);
    endfunction

    function automatic logic [7:0] model_bits();
        logic [7:0] b;
        b    = '0;
        b[0] = rvfi_order != m_exp;
        b[1] = m_have && (rvfi_pc_rdata != m_prev);
        b[2] = rs_bad(rvfi_rs1_addr, rvfi_rs1_rdata);
        b[3] = rs_bad(rvfi_rs2_addr, rvfi_rs2_rdata);
        b[4] = (rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != 32'd0);
        b[5] = m_halted;
        b[6] = rvfi_trap && (rvfi_rd_addr != 5'd0);
        b[7] = !rvfi_trap && (rvfi_pc_wdata[1:0] != 2'b00);
        return b;
    endfunction

    function automatic void model_step();
        logic [7:0] b;
        b = rvfi_valid ? model_bits() : 8'd0;
        if (err_clear) begin
            m_err    = (b != 0);
            m_code   = b;
            m_fcode  = b;
            m_forder = (b != 0) ? rvfi_order : 64'd0;
            m_finsn  = (b != 0) ? rvfi_insn : 32'd0;
        end else if (b != 0) begin
            if (!m_err) begin
                m_fcode  = b;
                m_forder = rvfi_order;
                m_finsn  = rvfi_insn;
            end
            m_err  = 1'b1;
            m_code = m_code | b;
        end
        if (rvfi_valid) begin
            if (!rvfi_trap && rvfi_rd_addr != 0) begin
                m_sh[rvfi_rd_addr]  = rvfi_rd_wdata;
                m_shv[rvfi_rd_addr] = 1'b1;
            end
            m_exp  = rvfi_order + 64'd1;
            m_prev = rvfi_pc_wdata;
            m_have = 1'b1;
            if (m_retired != '1) m_retired = m_retired + 64'd1;
            if (rvfi_halt) m_halted = 1'b1;
        end
    endfunction

    // Every-cycle comparison of all outputs against the model
    always @(negedge clock) begin
        if (cmp_en) begin
            chk("err", {63'd0, err}, {63'd0, m_err});
            chk("err_code", {56'd0, err_code}, {56'd0, m_code});
            chk("err_first_code", {56'd0, err_first_code}, {56'd0, m_fcode});
            chk("err_first_order", err_first_order, m_forder);
            chk("err_first_insn", {32'd0, err_first_insn}, {32'd0, m_finsn});
            chk("retired", retired, m_retired);
            chk("halted", {63'd0, halted}, {63'd0, m_halted});
        end
    end

    task automatic step();
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        model_reset();
        #2 reset = 1'b1;
    endtask

    task automatic idle();
        rvfi_valid = 1'b0;
        err_clear  = 1'b0;
        step();
    endtask

    task automatic beat(input logic [63:0] ord, input logic [31:0] pcr, input logic [31:0] pcw,
                        input logic [4:0] rd, input logic [31:0] wd,
                        input logic [4:0] a1, input logic [31:0] d1,
                        input logic [4:0] a2, input logic [31:0] d2,
                        input bit trap, input bit halt, input bit clr);
        rvfi_valid = 1'b1; rvfi_order = ord; rvfi_insn = $urandom;
        rvfi_pc_rdata = pcr; rvfi_pc_wdata = pcw;
        rvfi_rd_addr = rd; rvfi_rd_wdata = wd;
        rvfi_rs1_addr = a1; rvfi_rs1_rdata = d1;
        rvfi_rs2_addr = a2; rvfi_rs2_rdata = d2;
        rvfi_trap = trap; rvfi_halt = halt; err_clear = clr;
        step();
        rvfi_valid = 1'b0; rvfi_trap = 1'b0; rvfi_halt = 1'b0; err_clear = 1'b0;
    endtask

    function automatic logic [31:0] pick_rdata(logic [4:0] a);
        if ($urandom_range(0, 19) == 0) return $urandom;
        if (a == 5'd0) return 32'd0;
        if (m_shv[a]) return m_sh[a];
        return $urandom;
    endfunction

    initial begin
        logic [63:0] ord;
        logic [31:0] pcr, pcw, wd;
        logic [4:0]  rd, a1, a2;
        model_reset();
        cmp_en = 1'b1;
        @(negedge clock);
        reset = 1'b1;

        // Clean trace with a read-after-write through x1
        do_reset();
        beat(0, 32'h0, 32'h4, 5'd1, 32'd5, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0, 0);
        beat(1, 32'h4, 32'h8, 5'd0, 32'd0, 5'd1, 32'd5, 5'd0, 32'd0, 0, 0, 0);
        beat(2, 32'h8, 32'hC, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0, 0);
        chk("t1 err", {63'd0, err}, 64'd0);
        chk("t1 retired", retired, 64'd3);

        // PC discontinuity on beat 1
        do_reset();
        beat(0, 32'h0, 32'h4, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0, 0);
        beat(1, 32'hC, 32'h10, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0, 0);
        chk("t2 err", {63'd0, err}, 64'd1);
        chk("t2 err_code", {56'd0, err_code}, 64'h02);
        chk("t2 first_order", err_first_order, 64'd1);

        // RS2 mismatch, then an order jump
        do_reset();
        beat(0, 32'h0, 32'h4, 5'd3, 32'hAA, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0, 0);
        beat(1, 32'h4, 32'h8, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 32'hAB, 0, 0, 0);
        beat(4, 32'h8, 32'hC, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0, 0);
        chk("t3 first_code", {56'd0, err_first_code}, 64'h08);
        chk("t3 err_code", {56'd0, err_code}, 64'h09);

        // Trap with rd write, x0 write, then x2 read stays unchecked
        do_reset();
        beat(0, 32'h0, 32'h4, 5'd2, 32'd9, 5'd0, 32'd0, 5'd0, 32'd0, 1, 0, 0);
        beat(1, 32'h4, 32'h8, 5'd0, 32'd7, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0, 0);
        beat(2, 32'h8, 32'hC, 5'd0, 32'd0, 5'd2, 32'h123, 5'd0, 32'd0, 0, 0, 0);
        chk("t4 err_code", {56'd0, err_code}, 64'h50);
        chk("t4 first_code", {56'd0, err_first_code}, 64'h40);

        // Beat after halt
        do_reset();
        beat(0, 32'h0, 32'h4, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 0, 1, 0);
        beat(1, 32'h4, 32'h8, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0, 0);
        chk("t5 halted", {63'd0, halted}, 64'd1);
        chk("t5 err_code", {56'd0, err_code}, 64'h20);

        // err_clear in the same cycle as a PC error
        do_reset();
        beat(0, 32'h0, 32'h4, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0, 0);
        beat(5, 32'h4, 32'h8, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0, 0);
        chk("t5b pre-clear code", {56'd0, err_code}, 64'h01);
        beat(6, 32'h20, 32'h24, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0, 1);
        chk("t5b err_code", {56'd0, err_code}, 64'h02);
        chk("t5b first_order", err_first_order, 64'd6);

        // Reset mid-trace, restart at order 0
        do_reset();
        beat(0, 32'h0, 32'h4, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0, 0);
        beat(1, 32'h4, 32'h8, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0, 0);
        do_reset();
        chk("t6 retired after reset", retired, 64'd0);
        beat(0, 32'h100, 32'h104, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0, 0);
        chk("t6 err", {63'd0, err}, 64'd0);
        chk("t6 retired", retired, 64'd1);

        // Randomized trace, mostly consistent with occasional faults
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset();
            end else if (r < 15) begin
                idle();
            end else begin
                ord = ($urandom_range(0, 24) == 0) ? m_exp + 64'd2 : m_exp;
                pcr = (m_have && $urandom_range(0, 24) != 0) ? m_prev : ($urandom & 32'hFFFF_FFFC);
                pcw = pcr + (($urandom_range(0, 39) == 0) ? 32'd2 : 32'd4);
                rd  = 5'($urandom_range(0, 31));
                wd  = $urandom;
                if (rd == 5'd0 && $urandom_range(0, 9) != 0) wd = 32'd0;
                a1  = 5'($urandom_range(0, 31));
                a2  = 5'($urandom_range(0, 31));
                beat(ord, pcr, pcw, rd, wd, a1, pick_rdata(a1), a2, pick_rdata(a2),
                     $urandom_range(0, 29) == 0, $urandom_range(0, 249) == 0,
                     $urandom_range(0, 29) == 0);
            end
        end

        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
